// File: rtl/ram_wait_port.sv
// rtl/ram_wait_port.sv - single-port word RAM with req/done handshake, wait states and byte enables
module ram_wait_port #(
   parameter int DWIDTH      = 32,
   parameter int ADEPTH      = 256,
   parameter int AWIDTH      = $clog2(ADEPTH),
   parameter int WAIT_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req,
   input  logic                  we,
   input  logic [DWIDTH/8-1:0]   be,
   input  logic [AWIDTH-1:0]     addr,
   input  logic [DWIDTH-1:0]     wdata,
   output logic                  ready,
   output logic                  done,
   output logic                  err,
   output logic [DWIDTH-1:0]     rdata
);

   localparam int NBE = DWIDTH / 8;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;
   localparam logic [AWIDTH:0] DEPTH_L = ADEPTH[AWIDTH:0];

   logic [0:0]        state;
   logic [3:0]        cnt;
   logic              we_q;
   logic [NBE-1:0]    be_q;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] wdata_q;
   logic [DWIDTH-1:0] mem [0:ADEPTH-1];

   logic in_range;
   logic access;

   assign ready    = (state == S_IDLE);
   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign access   = (state == S_BUSY) && (cnt == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         done    <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  we_q    <= we;
                  be_q    <= be;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  cnt     <= WAIT_CYCLES[3:0];
                  state   <= S_BUSY;
               end
            end
            default: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  // Read-before-write: rdata always returns the word as it was before this access.
                  rdata <= in_range ? mem[addr_q] : '0;
                  err   <= !in_range;
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Array has no reset so contents survive rst; an aborted write never reaches here.
   always_ff @(posedge clk) begin
      if (!rst && access && we_q && in_range) begin
         for (int i = 0; i < NBE; i++) begin
            if (be_q[i]) begin
               mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_wait_port.sv
// tb/tb_ram_wait_port.sv - directed checks of ram_wait_port (ADEPTH=200/WAIT=3 and ADEPTH=256/WAIT=0)
module tb_ram_wait_port;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req_v;
   logic        we;
   logic [3:0]  be;
   logic [7:0]  addr;
   logic [31:0] wdata;
   int          sel;

   logic        req_a, req_b;
   logic        ready_a, done_a, err_a;
   logic        ready_b, done_b, err_b;
   logic [31:0] rdata_a, rdata_b;

   assign req_a = req_v && (sel == 0);
   assign req_b = req_v && (sel == 1);

   ram_wait_port #(.DWIDTH(32), .ADEPTH(200), .WAIT_CYCLES(3)) dut_a (
      .clk(clk), .rst(rst), .req(req_a), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .ready(ready_a), .done(done_a), .err(err_a), .rdata(rdata_a)
   );

   ram_wait_port #(.DWIDTH(32), .ADEPTH(256), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .ready(ready_b), .done(done_b), .err(err_b), .rdata(rdata_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input int s);
      return (s == 0) ? ready_a : ready_b;
   endfunction

   function automatic logic dn(input int s);
      return (s == 0) ? done_a : done_b;
   endfunction

   function automatic logic [31:0] rd(input int s);
      return (s == 0) ? rdata_a : rdata_b;
   endfunction

   function automatic logic er(input int s);
      return (s == 0) ? err_a : err_b;
   endfunction

   typedef struct {
      int          s;
      logic        w;
      logic [3:0]  b;
      logic [7:0]  a;
      logic [31:0] d;
      logic        ck;
      logic [31:0] erd;
      logic        eerr;
   } vec_t;

   vec_t tv [17];

   // One isolated access; latency is edges from the accept edge to the edge that raises done.
   task automatic txn(input vec_t v, input int idx);
      int lat;
      int exp_lat;
      string tag;
      tag = $sformatf("v%0d", idx);
      exp_lat = (v.s == 0) ? 4 : 1;
      @(negedge clk);
      sel = v.s;
      chk({tag, " ready"}, 32'(rdy(v.s)), 32'd1);
      req_v = 1'b1; we = v.w; be = v.b; addr = v.a; wdata = v.d;
      @(negedge clk);
      req_v = 1'b0;
      lat = 0;
      while (!dn(v.s) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      if (v.ck) chk({tag, " rdata"}, rd(v.s), v.erd);
      chk({tag, " err"}, 32'(er(v.s)), 32'(v.eerr));
   endtask

   // req held high over addrs 0..n-1; accepts must be WAIT+2 cycles apart, one done per accept.
   task automatic stream(input int s, input logic w, input logic [31:0] dbase, input logic ck,
                         input logic [31:0] ebase, input int n, input string tag);
      int cyc, nacc, ndone, low, gap;
      int acc [4];
      int dc [4];
      cyc = 0; nacc = 0; ndone = 0; low = 0;
      gap = (s == 0) ? 5 : 2;
      @(negedge clk);
      sel = s; we = w; be = 4'hF;
      while (ndone < n && cyc < 80) begin
         if (dn(s)) begin
            dc[ndone] = cyc;
            if (ck) chk($sformatf("%s rdata%0d", tag, ndone), rd(s), ebase + 32'(ndone));
            ndone++;
         end
         if (rdy(s)) begin
            if (nacc < n) begin
               acc[nacc] = cyc;
               addr = 8'(nacc);
               wdata = dbase + 32'(nacc);
               req_v = 1'b1;
               nacc++;
            end else begin
               req_v = 1'b0;
            end
         end else begin
            low++;
         end
         @(negedge clk);
         cyc++;
      end
      req_v = 1'b0;
      chk({tag, " done count"}, 32'(ndone), 32'(n));
      chk({tag, " accept count"}, 32'(nacc), 32'(n));
      for (int k = 0; k < ndone; k++)
         chk($sformatf("%s done%0d delay", tag, k), 32'(dc[k] - acc[k]), 32'(gap));
      for (int k = 1; k < nacc; k++)
         chk($sformatf("%s accept spacing%0d", tag, k), 32'(acc[k] - acc[k-1]), 32'(gap));
      chk({tag, " ready low cycles"}, 32'(low), 32'(n * (gap - 1)));
   endtask

   initial begin
      logic seen;
      tv[0]  = '{0, 1'b1, 4'hF,    8'd10,  32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
      tv[1]  = '{0, 1'b1, 4'hF,    8'd10,  32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 1'b0};
      tv[2]  = '{0, 1'b0, 4'h0,    8'd10,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
      tv[3]  = '{0, 1'b1, 4'hF,    8'd5,   32'h11223344, 1'b0, 32'h0,        1'b0};
      tv[4]  = '{0, 1'b1, 4'b0101, 8'd5,   32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0};
      tv[5]  = '{0, 1'b0, 4'h0,    8'd5,   32'h0,        1'b1, 32'h11BB33DD, 1'b0};
      tv[6]  = '{0, 1'b1, 4'h0,    8'd5,   32'h0,        1'b1, 32'h11BB33DD, 1'b0};
      tv[7]  = '{0, 1'b0, 4'hF,    8'd5,   32'h0,        1'b1, 32'h11BB33DD, 1'b0};
      tv[8]  = '{0, 1'b1, 4'hF,    8'd250, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1};
      tv[9]  = '{0, 1'b0, 4'h0,    8'd250, 32'h0,        1'b1, 32'h0,        1'b1};
      tv[10] = '{0, 1'b1, 4'hF,    8'd199, 32'h5,        1'b0, 32'h0,        1'b0};
      tv[11] = '{0, 1'b0, 4'h0,    8'd199, 32'h0,        1'b1, 32'h5,        1'b0};
      tv[12] = '{0, 1'b1, 4'hF,    8'd200, 32'h1,        1'b1, 32'h0,        1'b1};
      tv[13] = '{0, 1'b1, 4'hF,    8'd0,   32'd100,      1'b0, 32'h0,        1'b0};
      tv[14] = '{0, 1'b1, 4'hF,    8'd1,   32'd101,      1'b0, 32'h0,        1'b0};
      tv[15] = '{0, 1'b1, 4'hF,    8'd2,   32'd102,      1'b0, 32'h0,        1'b0};
      tv[16] = '{0, 1'b1, 4'hF,    8'd7,   32'h0,        1'b0, 32'h0,        1'b0};

      rst = 1'b1; req_v = 1'b0; sel = 0; we = 1'b0; be = 4'h0; addr = 8'd0; wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset ready_a", 32'(ready_a), 32'd1);
      chk("reset done_a", 32'(done_a), 32'd0);
      chk("reset err_a", 32'(err_a), 32'd0);
      chk("reset rdata_a", rdata_a, 32'h0);
      chk("reset ready_b", 32'(ready_b), 32'd1);
      chk("reset rdata_b", rdata_b, 32'h0);

      for (int i = 0; i < 17; i++) txn(tv[i], i);

      stream(0, 1'b0, 32'h0, 1'b1, 32'd100, 3, "a_rd_stream");

      // Reset two edges after accepting a write to addr 7: no done, memory untouched.
      @(negedge clk);
      sel = 0; we = 1'b1; be = 4'hF; addr = 8'd7; wdata = 32'h12345678; req_v = 1'b1;
      @(negedge clk);
      req_v = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort ready", 32'(ready_a), 32'd1);
      chk("abort done", 32'(done_a), 32'd0);
      chk("abort rdata", rdata_a, 32'h0);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done_a) seen = 1'b1;
      end
      chk("abort no done", 32'(seen), 32'd0);
      txn('{0, 1'b0, 4'h0, 8'd7, 32'h0, 1'b1, 32'h0, 1'b0}, 99);

      stream(1, 1'b1, 32'hA0, 1'b0, 32'h0, 4, "b_wr_stream");
      stream(1, 1'b0, 32'h0, 1'b1, 32'hA0, 4, "b_rd_stream");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
